// File: rtl/latch_ctrl_pkg.sv
// Shared types and constants for the gated-latch write sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        PULSE  = 3'd2,
        HOLD   = 3'd3,
        VERIFY = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Two synchronizer stages plus one compare cycle.
    localparam int VERIFY_CYC = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset value 0.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none (free-running).
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
// Only compiled in when LATCH_VERIFY_EN is defined; it has no user otherwise.
`ifdef LATCH_VERIFY_EN
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/latch_write_ctrl.sv
// Timed write sequencer for a gated D latch: data setup, gate pulse, data hold, optional readback.
// Latency: accept edge -> done_valid = SETUP_CYC+PULSE_CYC+HOLD_CYC (+VERIFY_CYC with verify).
// Backpressure: req_ready only in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst_n (async assert, sync release); req_valid/req_data/req_ready request handshake;
//        lat_d/lat_g registered latch drive; lat_q latch readback (async to clk);
//        done_valid/done_match completion pulse and readback result; busy = not IDLE.
// Build option: LATCH_VERIFY_EN adds the VERIFY state and the lat_q synchronizer; without it
//        lat_q is ignored and done_match reads 1 with every done pulse.
module latch_write_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_data,
    output logic req_ready,
    output logic lat_d,
    output logic lat_g,
    input  logic lat_q,
    output logic done_valid,
    output logic done_match,
    output logic busy
);

`ifdef LATCH_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    localparam int MAX_PHASE = max3(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC),
                                    VERIFY_EN ? VERIFY_CYC : 1, 1);

    // Elaboration-time parameter sanity.
    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_phase
        $error("latch_write_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end
    if (MAX_PHASE > (1 << CNT_W) - 1) begin : g_bad_cnt_w
        $error("latch_write_ctrl: CNT_W too narrow for the longest phase");
    end

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lat_d_nxt;
    logic             match_bit;

`ifdef LATCH_VERIFY_EN
    localparam logic [CNT_W-1:0] VERIFY_LAST = CNT_W'(VERIFY_CYC - 1);

    logic q_sync;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lat_q),
        .q     (q_sync)
    );

    // Only consumed on the last VERIFY cycle, when the synchronizer has settled.
    assign match_bit = (q_sync == lat_d);
`else
    logic unused_lat_q;
    assign unused_lat_q = lat_q;
    assign match_bit    = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_d_nxt = lat_d;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                    lat_d_nxt = req_data;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nxt = PULSE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
`ifdef LATCH_VERIFY_EN
                    state_nxt = VERIFY;
`else
                    state_nxt = DONE;
`endif
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef LATCH_VERIFY_EN
            VERIFY: begin
                if (cnt == VERIFY_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so lat_g never glitches.
    // DONE is only entered from the final VERIFY cycle (or HOLD without
    // verify), so gating match_bit with the DONE entry samples it there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_d      <= 1'b0;
            lat_g      <= 1'b0;
            done_valid <= 1'b0;
            done_match <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lat_d      <= lat_d_nxt;
            lat_g      <= (state_nxt == PULSE);
            done_valid <= (state_nxt == DONE);
            done_match <= (state_nxt == DONE) && match_bit;
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_latch_write_ctrl.sv
`timescale 1ns/1ps
module tb_latch_write_ctrl;

    localparam int S = 2;
    localparam int P = 4;
    localparam int H = 2;
`ifdef LATCH_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int LAT  = S + P + H + (VER ? 3 : 0);
    localparam int LAT2 = 3 + (VER ? 3 : 0);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic req_valid = 1'b0, req_data = 1'b0;
    logic req_ready, lat_d, lat_g, lat_q, done_valid, done_match, busy;

    // Behavioural latch with an optional stuck-at-0 Q fault.
    logic q_latch = 1'b0;
    logic stuck = 1'b0;
    always @(lat_g or lat_d) if (lat_g) q_latch = lat_d;
    assign lat_q = stuck ? 1'b0 : q_latch;

    latch_write_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .lat_d(lat_d), .lat_g(lat_g), .lat_q(lat_q),
        .done_valid(done_valid), .done_match(done_match), .busy(busy)
    );

    // Minimum-parameter instance.
    logic rv2 = 1'b0, rd2 = 1'b0;
    logic rr2, ld2, lg2, lq2, dv2, dm2, bz2;
    assign lq2 = ld2;

    latch_write_ctrl #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_data(rd2),
        .req_ready(rr2), .lat_d(ld2), .lat_g(lg2), .lat_q(lq2),
        .done_valid(dv2), .done_match(dm2), .busy(bz2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time since last acceptance decides every output.
    int cyc = 0;
    int acc = -1000;
    bit m_ld = 1'b0;
    bit m_match = 1'b1;

    task automatic step();
        int t;
        bit e_busy;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            acc  = -1000;
            m_ld = 1'b0;
        end else if ((cyc - 1 - acc) > LAT && req_valid) begin
            acc     = cyc;
            m_ld    = req_data;
            m_match = VER ? ((stuck ? 1'b0 : req_data) == req_data) : 1'b1;
        end
        @(negedge clk);
        t = cyc - acc;
        e_busy = (t >= 0 && t <= LAT);
        chk("ready", req_ready, !e_busy);
        chk("busy", busy, e_busy);
        chk("lat_d", lat_d, m_ld);
        chk("lat_g", lat_g, (t >= S && t < S + P));
        chk("done_valid", done_valid, (t == LAT));
        chk("done_match", done_match, (t == LAT) && m_match);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("wait_idle", req_ready, 1);
    endtask

    typedef struct {
        bit data;
        bit stk;
        bit exp_ld;
        bit exp_match;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, gfirst, gcnt, dlat, nacc, last;
        bit m, prevb, d;

        tbl[0] = '{data: 1'b1, stk: 1'b0, exp_ld: 1'b1, exp_match: 1'b1};
        tbl[1] = '{data: 1'b0, stk: 1'b0, exp_ld: 1'b0, exp_match: 1'b1};
        tbl[2] = '{data: 1'b1, stk: 1'b1, exp_ld: 1'b1, exp_match: VER ? 1'b0 : 1'b1};
        tbl[3] = '{data: 1'b0, stk: 1'b1, exp_ld: 1'b0, exp_match: 1'b1};

        // Reset held 5 cycles.
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rst_ready", req_ready, 1);
        chk("rst_lat_g", lat_g, 0);
        chk("rst_lat_d", lat_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        rst_n = 1'b1;
        step();

        // Table-driven single writes.
        for (int v = 0; v < 4; v++) begin
            wait_idle();
            stuck     = tbl[v].stk;
            req_valid = 1'b1;
            req_data  = tbl[v].data;
            step();
            a = cyc;
            req_valid = 1'b0;
            req_data  = ~tbl[v].data;
            gfirst = -1; gcnt = 0; dlat = -1; m = 1'b0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (lat_g) begin
                    if (gfirst < 0) gfirst = cyc - a;
                    gcnt++;
                end
                if (done_valid) begin
                    dlat = cyc - a;
                    m = done_match;
                    chk("tbl_lat_d", lat_d, tbl[v].exp_ld);
                    break;
                end
            end
            chk("tbl_latency", dlat, LAT);
            chk("tbl_gate_start", gfirst, S);
            chk("tbl_gate_len", gcnt, P);
            chk("tbl_match", m, tbl[v].exp_match);
            step();
            stuck = 1'b0;
        end

        // Continuous requests with alternating data while busy.
        wait_idle();
        req_valid = 1'b1;
        req_data  = 1'b1;
        nacc = 0; last = -1;
        for (int i = 0; i < 32; i++) begin
            prevb = busy;
            d = req_data;
            step();
            if (busy && !prevb) begin
                chk("rej_data", lat_d, d);
                if (last >= 0) chk("rej_spacing", cyc - last, LAT + 2);
                last = cyc;
                nacc++;
            end
            req_data = ~req_data;
        end
        req_valid = 1'b0;
        chk("rej_count", nacc, (32 - 1) / (LAT + 2) + 1);

        // Reset dropped in the middle of the gate pulse.
        wait_idle();
        req_valid = 1'b1;
        req_data  = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("mid_gate_open", lat_g, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lat_g", lat_g, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done_valid, 0);
        step();
        step();
        rst_n = 1'b1;
        nacc = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (done_valid) nacc++;
        end
        chk("mid_rst_no_done", nacc, 0);
        chk("mid_rst_idle", req_ready, 1);

        // Minimum parameters: one-cycle phases.
        chk("min_ready", rr2, 1);
        rv2 = 1'b1;
        rd2 = 1'b1;
        step();
        a = cyc;
        rv2 = 1'b0;
        chk("min_lat_d", ld2, 1);
        gcnt = 0; dlat = -1; m = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (lg2) gcnt++;
            if (dv2) begin
                dlat = cyc - a;
                m = dm2;
                break;
            end
        end
        chk("min_gate_len", gcnt, 1);
        chk("min_latency", dlat, LAT2);
        chk("min_match", m, 1);
        step();
        chk("min_idle", rr2, 1);

        // Random traffic against the reference model.
        wait_idle();
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) == 0);
            req_data  = 1'($urandom);
            step();
        end
        req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
